// File: rtl/fetch_redirect_pkg.sv
// Shared types and constants for the fetch_redirect front end.
package fetch_redirect_pkg;

  typedef enum logic [1:0] {
    FR_BOOT   = 2'd0,
    FR_RUN    = 2'd1,
    FR_SQUASH = 2'd2
  } fr_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int PAIR_BYTES  = 2 * INSTR_BYTES;

endpackage

// File: rtl/fetch_queue_buf.sv
// Circular instruction queue: two entries written per push, up to two read per pop.
// Flush clears pointers and count and overrides any push or pop in the same cycle.
module fetch_queue_buf
  import fetch_redirect_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [PC_WIDTH-1:0]    push_pc,
  input  logic [IWIDTH-1:0]      push_instr_0,
  input  logic [IWIDTH-1:0]      push_instr_1,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   valid_0,
  output logic                   valid_1,
  output logic [IWIDTH-1:0]      instr_0,
  output logic [IWIDTH-1:0]      instr_1,
  output logic [PC_WIDTH-1:0]    pc_0,
  output logic [PC_WIDTH-1:0]    pc_1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [IWIDTH-1:0]   instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       count_next;
  logic [AW-1:0]       wr_ptr_1;
  logic [1:0]          popped;
  logic [1:0]          slot_valid;
  logic [IWIDTH-1:0]   slot_instr [2];
  logic [PC_WIDTH-1:0] slot_pc    [2];

  assign wr_ptr_1 = wr_ptr_reg + AW'(1);

  // Outputs are forced to zero when their slot is empty.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [AW-1:0] idx;
      assign idx            = rd_ptr_reg + AW'(gi);
      assign slot_valid[gi] = count_reg > CW'(gi);
      assign slot_instr[gi] = slot_valid[gi] ? instr_mem[idx] : '0;
      assign slot_pc[gi]    = slot_valid[gi] ? pc_mem[idx] : '0;
    end
  endgenerate

  // 2'b10 when both slots leave, 2'b01 when only the head does.
  assign popped     = pop ? {slot_valid[1], slot_valid[0] & ~slot_valid[1]} : 2'd0;
  assign count_next = count_reg + (push ? CW'(2) : CW'(0)) - CW'(popped);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= push ? wr_ptr_reg + AW'(2) : wr_ptr_reg;
      rd_ptr_reg <= rd_ptr_reg + AW'(popped);
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr_reg] <= push_instr_0;
      instr_mem[wr_ptr_1]   <= push_instr_1;
      pc_mem[wr_ptr_reg]    <= push_pc;
      pc_mem[wr_ptr_1]      <= push_pc + PC_WIDTH'(INSTR_BYTES);
    end
  end

  assign count   = count_reg;
  assign valid_0 = slot_valid[0];
  assign valid_1 = slot_valid[1];
  assign instr_0 = slot_instr[0];
  assign instr_1 = slot_instr[1];
  assign pc_0    = slot_pc[0];
  assign pc_1    = slot_pc[1];

endmodule

// File: rtl/fetch_redirect.sv
// Fetch controller: owns the PC, issues paired fetches sized to guaranteed queue space,
// and squashes queued and in-flight work on an execute-lane redirect.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IWIDTH   = 32,
  parameter int                  DEPTH    = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                fr_i_clk,
  input  logic                fr_i_rst,
  output logic                fr_o_imem_req,
  output logic [PC_WIDTH-1:0] fr_o_imem_addr,
  input  logic                fr_i_imem_valid,
  input  logic [IWIDTH-1:0]   fr_i_imem_instr_0,
  input  logic [IWIDTH-1:0]   fr_i_imem_instr_1,
  input  logic                fr_i_redirect_0,
  input  logic                fr_i_redirect_1,
  input  logic [PC_WIDTH-1:0] fr_i_redirect_pc_0,
  input  logic [PC_WIDTH-1:0] fr_i_redirect_pc_1,
  input  logic                fr_i_dec_ready,
  output logic                fr_o_valid_0,
  output logic                fr_o_valid_1,
  output logic [IWIDTH-1:0]   fr_o_instr_0,
  output logic [IWIDTH-1:0]   fr_o_instr_1,
  output logic [PC_WIDTH-1:0] fr_o_pc_0,
  output logic [PC_WIDTH-1:0] fr_o_pc_1
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   REQ_LIMIT = (CW + 1)'(DEPTH - 2);

  fr_state_t           state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [PC_WIDTH-1:0] req_addr_reg;
  logic                outstanding_reg;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_target;
  logic [CW-1:0]       count;
  logic [CW:0]         inflight;
  logic [CW:0]         occupancy;
  logic                req;
  logic                push;

  assign redirect        = fr_i_redirect_0 | fr_i_redirect_1;
  assign redirect_target = fr_i_redirect_0 ? fr_i_redirect_pc_0 : fr_i_redirect_pc_1;
  assign inflight        = {{(CW - 1){1'b0}}, outstanding_reg, 1'b0};
  assign occupancy       = {1'b0, count} + inflight;

  // req depends on registered state only; a request raised in a redirect cycle is
  // cancelled by clearing outstanding, and its response lands in SQUASH and is dropped.
  always_comb begin
    req        = 1'b0;
    state_next = state_reg;
    pc_next    = pc_reg;
    unique case (state_reg)
      FR_BOOT:   state_next = FR_RUN;
      FR_RUN:    req = occupancy <= REQ_LIMIT;
      FR_SQUASH: begin
        req        = inflight <= REQ_LIMIT;
        state_next = FR_RUN;
      end
      default:   state_next = FR_BOOT;
    endcase
    if (req) pc_next = pc_reg + PC_WIDTH'(PAIR_BYTES);
    if (redirect) begin
      state_next = FR_SQUASH;
      pc_next    = redirect_target;
    end
  end

  always_ff @(posedge fr_i_clk or posedge fr_i_rst) begin
    if (fr_i_rst) begin
      state_reg       <= FR_BOOT;
      pc_reg          <= RESET_PC;
      req_addr_reg    <= RESET_PC;
      outstanding_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      outstanding_reg <= req & ~redirect;
      if (req) req_addr_reg <= pc_reg;
    end
  end

  assign push           = (state_reg == FR_RUN) && fr_i_imem_valid;
  assign fr_o_imem_req  = req;
  assign fr_o_imem_addr = pc_reg;

  fetch_queue_buf #(
    .PC_WIDTH (PC_WIDTH),
    .IWIDTH   (IWIDTH),
    .DEPTH    (DEPTH)
  ) u_queue (
    .clk          (fr_i_clk),
    .rst          (fr_i_rst),
    .flush        (redirect),
    .push         (push),
    .push_pc      (req_addr_reg),
    .push_instr_0 (fr_i_imem_instr_0),
    .push_instr_1 (fr_i_imem_instr_1),
    .pop          (fr_i_dec_ready),
    .count        (count),
    .valid_0      (fr_o_valid_0),
    .valid_1      (fr_o_valid_1),
    .instr_0      (fr_o_instr_0),
    .instr_1      (fr_o_instr_1),
    .pc_0         (fr_o_pc_0),
    .pc_1         (fr_o_pc_1)
  );

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: one-cycle memory model plus an address-stream reference
// (fetches and decoded PCs each run contiguously from the last redirect target).
`timescale 1ns/1ps
module tb_fetch_redirect;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_instr_0 = '0, imem_instr_1 = '0;
  logic        redirect_0 = 1'b0, redirect_1 = 1'b0;
  logic [31:0] redirect_pc_0 = '0, redirect_pc_1 = '0;
  logic        dec_ready = 1'b0;
  logic        valid_0, valid_1;
  logic [31:0] instr_0, instr_1, pc_0, pc_1;

  int          checks_total = 0;
  int          checks_passed = 0;
  int          consumed = 0;
  logic [31:0] exp_fetch = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] salt = '0;

  fetch_redirect #(
    .PC_WIDTH (32),
    .IWIDTH   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .fr_i_clk           (clk),
    .fr_i_rst           (rst),
    .fr_o_imem_req      (imem_req),
    .fr_o_imem_addr     (imem_addr),
    .fr_i_imem_valid    (imem_valid),
    .fr_i_imem_instr_0  (imem_instr_0),
    .fr_i_imem_instr_1  (imem_instr_1),
    .fr_i_redirect_0    (redirect_0),
    .fr_i_redirect_1    (redirect_1),
    .fr_i_redirect_pc_0 (redirect_pc_0),
    .fr_i_redirect_pc_1 (redirect_pc_1),
    .fr_i_dec_ready     (dec_ready),
    .fr_o_valid_0       (valid_0),
    .fr_o_valid_1       (valid_1),
    .fr_o_instr_0       (instr_0),
    .fr_o_instr_1       (instr_1),
    .fr_o_pc_0          (pc_0),
    .fr_o_pc_1          (pc_1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Instructions requested but not yet handed to decode.
  function automatic int pending();
    return int'((exp_fetch - exp_pc) >> 2);
  endfunction

  // Advance one clock: update the stream model, then answer last cycle's request.
  task automatic drive_cycle();
    logic        r;
    logic [31:0] a;
    r = imem_req;
    a = imem_addr;
    if (redirect_0 || redirect_1) begin
      exp_fetch = redirect_0 ? redirect_pc_0 : redirect_pc_1;
      exp_pc    = exp_fetch;
    end else begin
      if (r) exp_fetch = exp_fetch + 32'd8;
      if (dec_ready) begin
        exp_pc   = exp_pc + 32'(4 * (int'(valid_0) + int'(valid_1)));
        consumed = consumed + int'(valid_0) + int'(valid_1);
      end
    end
    @(posedge clk);
    #1;
    imem_valid   = r;
    imem_instr_0 = mem_word(a);
    imem_instr_1 = mem_word(a + 32'd4);
    redirect_0   = 1'b0;
    redirect_1   = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem_req); else checks_passed++;
    checks_total++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); else checks_passed++;
    checks_total++; if ({valid_0, valid_1} !== 2'b00) $display("FAIL reset_valid: got %b want 00", {valid_0, valid_1}); else checks_passed++;
    checks_total++; if ({instr_0, pc_0, instr_1, pc_1} !== 128'h0) $display("FAIL reset_data: got %h %h %h %h want 0", instr_0, pc_0, instr_1, pc_1); else checks_passed++;
    rst       = 1'b0;
    exp_fetch = RESET_PC;
    exp_pc    = RESET_PC;
  endtask

  task automatic test_fetch_latency();
    dec_ready = 1'b1;
    checks_total++; if (imem_req !== 1'b0) $display("FAIL boot_req: got %0b want 0", imem_req); else checks_passed++;
    drive_cycle();
    checks_total++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) $display("FAIL first_req: got %0b@%h want 1@%h", imem_req, imem_addr, RESET_PC); else checks_passed++;
    checks_total++; if (valid_0 !== 1'b0) $display("FAIL early_valid_c1: got %0b want 0", valid_0); else checks_passed++;
    drive_cycle();
    checks_total++; if (valid_0 !== 1'b0) $display("FAIL early_valid_c2: got %0b want 0", valid_0); else checks_passed++;
    drive_cycle();
    checks_total++; if ({valid_0, valid_1} !== 2'b11 || pc_0 !== RESET_PC || pc_1 !== RESET_PC + 32'd4) $display("FAIL first_pair: got v=%b pc=%h/%h want v=11 pc=%h/%h", {valid_0, valid_1}, pc_0, pc_1, RESET_PC, RESET_PC + 32'd4); else checks_passed++;
    checks_total++; if (instr_0 !== mem_word(RESET_PC) || instr_1 !== mem_word(RESET_PC + 32'd4)) $display("FAIL first_instr: got %h/%h want %h/%h", instr_0, instr_1, mem_word(RESET_PC), mem_word(RESET_PC + 32'd4)); else checks_passed++;
    for (int i = 0; i < 6; i++) begin
      checks_total++; if (imem_req !== 1'b1 || imem_addr !== exp_fetch) $display("FAIL stream_req: got %0b@%h want 1@%h", imem_req, imem_addr, exp_fetch); else checks_passed++;
      checks_total++; if (valid_1 !== 1'b1 || pc_0 !== exp_pc || instr_1 !== mem_word(exp_pc + 32'd4)) $display("FAIL stream_pop: got v1=%0b pc0=%h want v1=1 pc0=%h", valid_1, pc_0, exp_pc); else checks_passed++;
      drive_cycle();
    end
  endtask

  task automatic test_stall_fill();
    dec_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks_total++; if (imem_req !== (pending() <= DEPTH - 2)) $display("FAIL stall_req: got %0b with %0d pending", imem_req, pending()); else checks_passed++;
      drive_cycle();
    end
    checks_total++; if (pending() != DEPTH) $display("FAIL fill_level: got %0d want %0d", pending(), DEPTH); else checks_passed++;
    dec_ready = 1'b1;
    for (int i = 0; i < DEPTH / 2; i++) begin
      checks_total++; if ({valid_0, valid_1} !== 2'b11 || pc_0 !== exp_pc || pc_1 !== exp_pc + 32'd4 || instr_0 !== mem_word(exp_pc)) $display("FAIL drain: got v=%b pc=%h/%h want v=11 pc=%h/%h", {valid_0, valid_1}, pc_0, pc_1, exp_pc, exp_pc + 32'd4); else checks_passed++;
      drive_cycle();
    end
  endtask

  task automatic test_redirect_lane1();
    bit found = 0;
    dec_ready = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1;
      drive_cycle();
    end
    checks_total++; if (!found) $display("FAIL lane1_wait_req: got no request within 10 cycles want one"); else checks_passed++;
    redirect_1 = 1'b1; redirect_pc_1 = 32'h100;
    drive_cycle();
    checks_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL lane1_req: got %0b@%h want 1@100", imem_req, imem_addr); else checks_passed++;
    checks_total++; if (valid_0 !== 1'b0) $display("FAIL lane1_flush: got v0=%0b want 0", valid_0); else checks_passed++;
    drive_cycle();
    checks_total++; if (valid_0 !== 1'b0 || imem_addr !== 32'h108) $display("FAIL lane1_drop: got v0=%0b addr=%h want 0 and 108", valid_0, imem_addr); else checks_passed++;
    drive_cycle();
    checks_total++; if ({valid_0, valid_1} !== 2'b11 || pc_0 !== 32'h100 || pc_1 !== 32'h104 || instr_1 !== mem_word(32'h104)) $display("FAIL lane1_pair: got v=%b pc=%h/%h want 11 100/104", {valid_0, valid_1}, pc_0, pc_1); else checks_passed++;
  endtask

  task automatic test_redirect_both();
    dec_ready = 1'b1;
    drive_cycle();
    redirect_0 = 1'b1; redirect_pc_0 = 32'h200;
    redirect_1 = 1'b1; redirect_pc_1 = 32'h300;
    drive_cycle();
    checks_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL both_req: got %0b@%h want 1@200", imem_req, imem_addr); else checks_passed++;
    drive_cycle();
    drive_cycle();
    for (int i = 0; i < 4; i++) begin
      checks_total++; if (valid_0 !== 1'b1 || pc_0 !== exp_pc || exp_pc < 32'h200 || exp_pc >= 32'h300) $display("FAIL both_stream: got v0=%0b pc0=%h want 1 %h", valid_0, pc_0, exp_pc); else checks_passed++;
      checks_total++; if (imem_addr !== exp_fetch) $display("FAIL both_fetch: got %h want %h", imem_addr, exp_fetch); else checks_passed++;
      drive_cycle();
    end
  endtask

  task automatic test_redirect_squash();
    dec_ready = 1'b1;
    redirect_0 = 1'b1; redirect_pc_0 = 32'h200;
    drive_cycle();
    checks_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL sq_first_req: got %0b@%h want 1@200", imem_req, imem_addr); else checks_passed++;
    redirect_1 = 1'b1; redirect_pc_1 = 32'h400;
    drive_cycle();
    checks_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) $display("FAIL sq_second_req: got %0b@%h want 1@400", imem_req, imem_addr); else checks_passed++;
    checks_total++; if (valid_0 !== 1'b0) $display("FAIL sq_valid_a: got %0b want 0", valid_0); else checks_passed++;
    drive_cycle();
    checks_total++; if (valid_0 !== 1'b0) $display("FAIL sq_drop_200: got v0=%0b pc0=%h want 0", valid_0, pc_0); else checks_passed++;
    drive_cycle();
    checks_total++; if ({valid_0, valid_1} !== 2'b11 || pc_0 !== 32'h400 || pc_1 !== 32'h404) $display("FAIL sq_pair: got v=%b pc=%h/%h want 11 400/404", {valid_0, valid_1}, pc_0, pc_1); else checks_passed++;
  endtask

  task automatic test_reset_midstream();
    dec_ready = 1'b0;
    for (int i = 0; i < 12; i++) drive_cycle();
    checks_total++; if (valid_1 !== 1'b1) $display("FAIL mid_full: got v1=%0b want 1", valid_1); else checks_passed++;
    #2 rst = 1'b1;
    #1;
    checks_total++; if ({valid_0, valid_1, imem_req} !== 3'b000 || pc_0 !== 32'h0) $display("FAIL mid_async: got v=%b req=%0b pc0=%h want 00 0 0", {valid_0, valid_1}, imem_req, pc_0); else checks_passed++;
    checks_total++; if (imem_addr !== RESET_PC) $display("FAIL mid_addr: got %h want %h", imem_addr, RESET_PC); else checks_passed++;
    imem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_fetch = RESET_PC;
    exp_pc    = RESET_PC;
    dec_ready = 1'b1;
    checks_total++; if (imem_req !== 1'b0) $display("FAIL mid_boot_req: got %0b want 0", imem_req); else checks_passed++;
    imem_valid   = 1'b1;
    imem_instr_0 = mem_word(32'h500);
    imem_instr_1 = mem_word(32'h504);
    drive_cycle();
    checks_total++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC || valid_0 !== 1'b0) $display("FAIL mid_restart: got req=%0b@%h v0=%0b want 1@%h v0=0", imem_req, imem_addr, valid_0, RESET_PC); else checks_passed++;
    drive_cycle();
    checks_total++; if (valid_0 !== 1'b0) $display("FAIL mid_stray: got v0=%0b pc0=%h want 0", valid_0, pc_0); else checks_passed++;
    drive_cycle();
    checks_total++; if (valid_0 !== 1'b1 || pc_0 !== RESET_PC || instr_0 !== mem_word(RESET_PC)) $display("FAIL mid_first: got v0=%0b pc0=%h want 1 %h", valid_0, pc_0, RESET_PC); else checks_passed++;
  endtask

  task automatic test_random();
    int start;
    start = consumed;
    for (int i = 0; i < 400; i++) begin
      dec_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect_0    = 1'($urandom_range(0, 1));
        redirect_1    = ~redirect_0 | 1'($urandom_range(0, 1));
        redirect_pc_0 = 32'($urandom_range(0, 4095)) << 2;
        redirect_pc_1 = 32'($urandom_range(0, 4095)) << 2;
      end
      checks_total++; if (imem_req !== (pending() <= DEPTH - 2)) $display("FAIL rnd_req: cycle %0d got %0b with %0d pending", i, imem_req, pending()); else checks_passed++;
      if (imem_req) begin
        checks_total++; if (imem_addr !== exp_fetch) $display("FAIL rnd_addr: cycle %0d got %h want %h", i, imem_addr, exp_fetch); else checks_passed++;
      end
      if (valid_0) begin
        checks_total++; if (pc_0 !== exp_pc || instr_0 !== mem_word(exp_pc)) $display("FAIL rnd_slot0: cycle %0d got %h/%h want %h/%h", i, pc_0, instr_0, exp_pc, mem_word(exp_pc)); else checks_passed++;
      end else begin
        checks_total++; if ({valid_1, pc_0, instr_0} !== 65'h0) $display("FAIL rnd_empty: cycle %0d got v1=%0b pc0=%h i0=%h want all 0", i, valid_1, pc_0, instr_0); else checks_passed++;
      end
      if (valid_1) begin
        checks_total++; if (pc_1 !== exp_pc + 32'd4 || instr_1 !== mem_word(exp_pc + 32'd4)) $display("FAIL rnd_slot1: cycle %0d got %h/%h want %h", i, pc_1, instr_1, exp_pc + 32'd4); else checks_passed++;
      end
      drive_cycle();
    end
    checks_total++; if (consumed - start < 100) $display("FAIL rnd_progress: got %0d instructions want at least 100", consumed - start); else checks_passed++;
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_fetch_latency();
    test_stall_fill();
    test_redirect_lane1();
    test_redirect_both();
    test_redirect_squash();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
